// File: rtl/multi_alarm_clock_if.sv
// Front-panel/register bundle for multi_alarm_clock: time and alarm programming,
// snooze/dismiss requests in, time of day and ringing status out.
interface multi_alarm_clock_if #(
    parameter int NUM_ALARMS = 4,
    parameter int IW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
);
    logic                  sec_tick;
    logic                  set_time;
    logic [4:0]            time_hours;
    logic [5:0]            time_minutes;
    logic                  alarm_wr;
    logic [IW-1:0]         alarm_idx;
    logic [4:0]            alarm_hours;
    logic [5:0]            alarm_minutes;
    logic                  alarm_enable;
    logic                  snooze;
    logic                  dismiss;
    logic [4:0]            cur_hours;
    logic [5:0]            cur_minutes;
    logic [5:0]            cur_seconds;
    logic                  alarm_ringing;
    logic [IW-1:0]         ringing_idx;
    logic [NUM_ALARMS-1:0] armed;

    modport master (
        output sec_tick, set_time, time_hours, time_minutes,
        output alarm_wr, alarm_idx, alarm_hours, alarm_minutes, alarm_enable,
        output snooze, dismiss,
        input  cur_hours, cur_minutes, cur_seconds, alarm_ringing, ringing_idx, armed
    );

    modport slave (
        input  sec_tick, set_time, time_hours, time_minutes,
        input  alarm_wr, alarm_idx, alarm_hours, alarm_minutes, alarm_enable,
        input  snooze, dismiss,
        output cur_hours, cur_minutes, cur_seconds, alarm_ringing, ringing_idx, armed
    );
endinterface

// File: rtl/multi_alarm_clock.sv
// 24-hour clock with NUM_ALARMS programmable alarms, one ringing output, snooze and dismiss.
// Define ALARM_AUTOSTOP_EN to build the ring timer that silences an unattended alarm after RING_MINUTES.
module multi_alarm_clock #(
    parameter int  NUM_ALARMS     = 4,
    parameter int  SNOOZE_MINUTES = 5,
    parameter int  RING_MINUTES   = 3,
    localparam int IW             = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input logic             clock,
    input logic             reset,
    multi_alarm_clock_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

    localparam logic [IW:0] SLOT_COUNT  = (IW + 1)'(NUM_ALARMS);
    localparam logic [5:0]  SNOOZE_LOAD = 6'(SNOOZE_MINUTES);

    if (NUM_ALARMS < 1 || NUM_ALARMS > 16 || SNOOZE_MINUTES < 1 || SNOOZE_MINUTES > 59 ||
        RING_MINUTES < 1 || RING_MINUTES > 59) begin : g_param_check
        $error("multi_alarm_clock: parameter out of range");
    end

    state_t                state;
    logic [4:0]            hours;
    logic [5:0]            minutes;
    logic [5:0]            seconds;
    logic [4:0]            alarm_h [NUM_ALARMS];
    logic [5:0]            alarm_m [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] alarm_en;
    logic [IW-1:0]         ring_idx;
    logic                  ringing;
    logic [5:0]            snooze_cnt;
`ifdef ALARM_AUTOSTOP_EN
    localparam logic [5:0] RING_LOAD = 6'(RING_MINUTES);
    logic [5:0]            ring_cnt;
`endif

    logic                  set_ok;
    logic                  wr_ok;
    logic                  tick;
    logic                  minute_roll;
    logic [5:0]            next_minutes;
    logic [4:0]            next_hours;
    logic                  disable_hit;
    logic                  match_any;
    logic [IW-1:0]         match_idx;

    // A rejected set_time behaves as if absent, so only a valid load swallows the tick.
    assign set_ok       = bus.set_time && (bus.time_hours <= 5'd23) && (bus.time_minutes <= 6'd59);
    assign wr_ok        = bus.alarm_wr && ({1'b0, bus.alarm_idx} < SLOT_COUNT) &&
                          (bus.alarm_hours <= 5'd23) && (bus.alarm_minutes <= 6'd59);
    assign tick         = bus.sec_tick && !set_ok;
    assign minute_roll  = tick && (seconds == 6'd59);
    assign next_minutes = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
    assign next_hours   = (minutes != 6'd59) ? hours : ((hours == 5'd23) ? 5'd0 : hours + 5'd1);
    assign disable_hit  = wr_ok && !bus.alarm_enable && (bus.alarm_idx == ring_idx);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hours   <= '0;
            minutes <= '0;
            seconds <= '0;
        end else if (set_ok) begin
            hours   <= bus.time_hours;
            minutes <= bus.time_minutes;
            seconds <= '0;
        end else if (tick) begin
            if (seconds == 6'd59) begin
                seconds <= '0;
                minutes <= next_minutes;
                hours   <= next_hours;
            end else begin
                seconds <= seconds + 6'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                alarm_h[i] <= '0;
                alarm_m[i] <= '0;
            end
            alarm_en <= '0;
        end else if (wr_ok) begin
            alarm_h[bus.alarm_idx]  <= bus.alarm_hours;
            alarm_m[bus.alarm_idx]  <= bus.alarm_minutes;
            alarm_en[bus.alarm_idx] <= bus.alarm_enable;
        end
    end

    // Descending scan so the lowest matching slot wins.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (alarm_en[i] && (alarm_h[i] == next_hours) && (alarm_m[i] == next_minutes)) begin
                match_any = 1'b1;
                match_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ring_idx   <= '0;
            ringing    <= 1'b0;
            snooze_cnt <= '0;
`ifdef ALARM_AUTOSTOP_EN
            ring_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (minute_roll && match_any) begin
                        state    <= RINGING;
                        ring_idx <= match_idx;
                        ringing  <= 1'b1;
`ifdef ALARM_AUTOSTOP_EN
                        ring_cnt <= RING_LOAD;
`endif
                    end
                end
                RINGING: begin
                    if (bus.dismiss || disable_hit) begin
                        state   <= IDLE;
                        ringing <= 1'b0;
                    end else if (bus.snooze) begin
                        state      <= SNOOZED;
                        ringing    <= 1'b0;
                        snooze_cnt <= SNOOZE_LOAD;
                    end
`ifdef ALARM_AUTOSTOP_EN
                    else if (minute_roll) begin
                        if (ring_cnt <= 6'd1) begin
                            state   <= IDLE;
                            ringing <= 1'b0;
                        end else begin
                            ring_cnt <= ring_cnt - 6'd1;
                        end
                    end
`endif
                end
                SNOOZED: begin
                    if (bus.dismiss || disable_hit) begin
                        state <= IDLE;
                    end else if (minute_roll) begin
                        if (snooze_cnt <= 6'd1) begin
                            state   <= RINGING;
                            ringing <= 1'b1;
`ifdef ALARM_AUTOSTOP_EN
                            ring_cnt <= RING_LOAD;
`endif
                        end else begin
                            snooze_cnt <= snooze_cnt - 6'd1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    ringing <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cur_hours     = hours;
    assign bus.cur_minutes   = minutes;
    assign bus.cur_seconds   = seconds;
    assign bus.alarm_ringing = ringing;
    assign bus.ringing_idx   = ring_idx;
    assign bus.armed         = alarm_en;
endmodule

// File: tb/tb_multi_alarm_clock.sv
// Scoreboard bench for multi_alarm_clock: expectations are queued as stimulus is driven
// and popped when the corresponding outputs are sampled.
module tb_multi_alarm_clock;
    localparam int NUM_ALARMS = 4;
    localparam int IW         = 2;

    logic clock = 1'b0;
    logic reset;

    multi_alarm_clock_if #(.NUM_ALARMS(NUM_ALARMS)) bus ();

    multi_alarm_clock #(
        .NUM_ALARMS(NUM_ALARMS),
        .SNOOZE_MINUTES(5),
        .RING_MINUTES(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] value;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] obs;
    int          checks = 0;
    int          passes = 0;

    function automatic logic [31:0] hms(input int h, input int m, input int s);
        return {15'd0, 5'(h), 6'(m), 6'(s)};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.sec_tick      = 1'b0;
        bus.set_time      = 1'b0;
        bus.time_hours    = '0;
        bus.time_minutes  = '0;
        bus.alarm_wr      = 1'b0;
        bus.alarm_idx     = '0;
        bus.alarm_hours   = '0;
        bus.alarm_minutes = '0;
        bus.alarm_enable  = 1'b0;
        bus.snooze        = 1'b0;
        bus.dismiss       = 1'b0;
    endtask

    task automatic set_clock_time(input logic [4:0] h, input logic [5:0] m);
        bus.set_time     = 1'b1;
        bus.time_hours   = h;
        bus.time_minutes = m;
        step();
        bus.set_time     = 1'b0;
    endtask

    task automatic write_slot(input logic [IW-1:0] idx, input logic [4:0] h, input logic [5:0] m,
                              input logic en);
        bus.alarm_wr      = 1'b1;
        bus.alarm_idx     = idx;
        bus.alarm_hours   = h;
        bus.alarm_minutes = m;
        bus.alarm_enable  = en;
        step();
        bus.alarm_wr      = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.sec_tick = 1'b1;
            step();
        end
        bus.sec_tick = 1'b0;
    endtask

    task automatic pulse(input logic snz, input logic dis);
        bus.snooze  = snz;
        bus.dismiss = dis;
        step();
        bus.snooze  = 1'b0;
        bus.dismiss = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        sb.push_back('{"reset_time", hms(0, 0, 0)});
        sb.push_back('{"reset_ringing", 32'd0});
        sb.push_back('{"reset_idx", 32'd0});
        sb.push_back('{"reset_armed", 32'd0});
        step();
        e = sb.pop_front(); checks++;
        obs = {15'd0, bus.cur_hours, bus.cur_minutes, bus.cur_seconds};
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;
        e = sb.pop_front(); checks++;
        obs = 32'(bus.alarm_ringing);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;
        e = sb.pop_front(); checks++;
        obs = 32'(bus.ringing_idx);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;
        e = sb.pop_front(); checks++;
        obs = 32'(bus.armed);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;
        @(negedge clock);
        reset = 1'b0;
        step();
    endtask

    task automatic test_rollover();
        sb.push_back('{"load_2359", hms(23, 59, 0)});
        set_clock_time(5'd23, 6'd59);
        e = sb.pop_front(); checks++;
        obs = {15'd0, bus.cur_hours, bus.cur_minutes, bus.cur_seconds};
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;

        sb.push_back('{"midnight_rollover", hms(0, 0, 0)});
        run_ticks(60);
        e = sb.pop_front(); checks++;
        obs = {15'd0, bus.cur_hours, bus.cur_minutes, bus.cur_seconds};
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;

        run_ticks(7);
        sb.push_back('{"bad_hour_ignored", hms(0, 0, 7)});
        set_clock_time(5'd24, 6'd10);
        e = sb.pop_front(); checks++;
        obs = {15'd0, bus.cur_hours, bus.cur_minutes, bus.cur_seconds};
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;

        sb.push_back('{"bad_minute_ignored", hms(0, 0, 7)});
        set_clock_time(5'd12, 6'd60);
        e = sb.pop_front(); checks++;
        obs = {15'd0, bus.cur_hours, bus.cur_minutes, bus.cur_seconds};
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;

        sb.push_back('{"set_beats_tick", hms(10, 20, 0)});
        bus.sec_tick = 1'b1;
        set_clock_time(5'd10, 6'd20);
        bus.sec_tick = 1'b0;
        e = sb.pop_front(); checks++;
        obs = {15'd0, bus.cur_hours, bus.cur_minutes, bus.cur_seconds};
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;
    endtask

    task automatic test_match();
        sb.push_back('{"bad_alarm_hour_ignored", 32'h0});
        write_slot(2'd0, 5'd24, 6'd0, 1'b1);
        e = sb.pop_front(); checks++;
        obs = 32'(bus.armed);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;

        sb.push_back('{"armed_slot2", 32'h4});
        write_slot(2'd2, 5'd7, 6'd30, 1'b1);
        e = sb.pop_front(); checks++;
        obs = 32'(bus.armed);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;

        set_clock_time(5'd7, 6'd29);
        sb.push_back('{"silent_at_072959", 32'd0});
        run_ticks(59);
        e = sb.pop_front(); checks++;
        obs = 32'(bus.alarm_ringing);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;

        sb.push_back('{"ring_at_0730", 32'd1});
        sb.push_back('{"ring_idx_2", 32'd2});
        run_ticks(1);
        e = sb.pop_front(); checks++;
        obs = 32'(bus.alarm_ringing);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;
        e = sb.pop_front(); checks++;
        obs = 32'(bus.ringing_idx);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;

        sb.push_back('{"dismiss_silences", 32'd0});
        pulse(1'b0, 1'b1);
        e = sb.pop_front(); checks++;
        obs = 32'(bus.alarm_ringing);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;
    endtask

    task automatic test_priority();
        write_slot(2'd1, 5'd6, 6'd0, 1'b1);
        write_slot(2'd3, 5'd6, 6'd0, 1'b1);
        set_clock_time(5'd5, 6'd59);
        sb.push_back('{"prio_ring", 32'd1});
        sb.push_back('{"prio_lowest_idx", 32'd1});
        run_ticks(60);
        e = sb.pop_front(); checks++;
        obs = 32'(bus.alarm_ringing);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;
        e = sb.pop_front(); checks++;
        obs = 32'(bus.ringing_idx);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;

        sb.push_back('{"dismiss_beats_snooze", 32'd0});
        pulse(1'b1, 1'b1);
        e = sb.pop_front(); checks++;
        obs = 32'(bus.alarm_ringing);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;

        sb.push_back('{"no_rering_0605", 32'd0});
        run_ticks(300);
        e = sb.pop_front(); checks++;
        obs = 32'(bus.alarm_ringing);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;

        write_slot(2'd1, 5'd6, 6'd0, 1'b0);
        sb.push_back('{"armed_after_clear", 32'h4});
        write_slot(2'd3, 5'd6, 6'd0, 1'b0);
        e = sb.pop_front(); checks++;
        obs = 32'(bus.armed);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;
    endtask

    task automatic test_snooze();
        set_clock_time(5'd7, 6'd29);
        sb.push_back('{"snz_first_ring", 32'd1});
        run_ticks(60);
        e = sb.pop_front(); checks++;
        obs = 32'(bus.alarm_ringing);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;

        sb.push_back('{"snooze_silences", 32'd0});
        pulse(1'b1, 1'b0);
        e = sb.pop_front(); checks++;
        obs = 32'(bus.alarm_ringing);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;

        sb.push_back('{"silent_073459", 32'd0});
        sb.push_back('{"time_073459", hms(7, 34, 59)});
        run_ticks(299);
        e = sb.pop_front(); checks++;
        obs = 32'(bus.alarm_ringing);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;
        e = sb.pop_front(); checks++;
        obs = {15'd0, bus.cur_hours, bus.cur_minutes, bus.cur_seconds};
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;

        sb.push_back('{"rering_073500", 32'd1});
        sb.push_back('{"rering_same_idx", 32'd2});
        run_ticks(1);
        e = sb.pop_front(); checks++;
        obs = 32'(bus.alarm_ringing);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;
        e = sb.pop_front(); checks++;
        obs = 32'(bus.ringing_idx);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;

        sb.push_back('{"snz_dismiss", 32'd0});
        pulse(1'b0, 1'b1);
        e = sb.pop_front(); checks++;
        obs = 32'(bus.alarm_ringing);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;
    endtask

    task automatic test_disable();
        set_clock_time(5'd7, 6'd29);
        run_ticks(60);
        sb.push_back('{"enabled_rewrite_keeps_ring", 32'd1});
        write_slot(2'd2, 5'd7, 6'd30, 1'b1);
        e = sb.pop_front(); checks++;
        obs = 32'(bus.alarm_ringing);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;

        pulse(1'b1, 1'b0);
        sb.push_back('{"disable_clears_armed2", 32'h0});
        write_slot(2'd2, 5'd7, 6'd30, 1'b0);
        e = sb.pop_front(); checks++;
        obs = 32'(bus.armed);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;

        sb.push_back('{"no_rering_after_disable", 32'd0});
        run_ticks(300);
        e = sb.pop_front(); checks++;
        obs = 32'(bus.alarm_ringing);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;

        write_slot(2'd2, 5'd7, 6'd40, 1'b1);
        set_clock_time(5'd7, 6'd39);
        run_ticks(60);
        sb.push_back('{"disable_while_ringing", 32'd0});
        write_slot(2'd2, 5'd7, 6'd40, 1'b0);
        e = sb.pop_front(); checks++;
        obs = 32'(bus.alarm_ringing);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;
    endtask

    task automatic test_autostop();
        write_slot(2'd0, 5'd8, 6'd0, 1'b1);
        set_clock_time(5'd7, 6'd59);
        sb.push_back('{"ring_0800", 32'd1});
        sb.push_back('{"ring_idx_0", 32'd0});
        run_ticks(60);
        e = sb.pop_front(); checks++;
        obs = 32'(bus.alarm_ringing);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;
        e = sb.pop_front(); checks++;
        obs = 32'(bus.ringing_idx);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;
`ifdef ALARM_AUTOSTOP_EN
        sb.push_back('{"still_ringing_080259", 32'd1});
        run_ticks(179);
        e = sb.pop_front(); checks++;
        obs = 32'(bus.alarm_ringing);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;
        sb.push_back('{"autostop_080300", 32'd0});
        run_ticks(1);
        e = sb.pop_front(); checks++;
        obs = 32'(bus.alarm_ringing);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;
`else
        sb.push_back('{"still_ringing_0810", 32'd1});
        run_ticks(600);
        e = sb.pop_front(); checks++;
        obs = 32'(bus.alarm_ringing);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;
`endif
        pulse(1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_ring();
        write_slot(2'd0, 5'd9, 6'd0, 1'b1);
        set_clock_time(5'd8, 6'd59);
        sb.push_back('{"ring_0900", 32'd1});
        run_ticks(60);
        e = sb.pop_front(); checks++;
        obs = 32'(bus.alarm_ringing);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;

        #2;
        sb.push_back('{"async_reset_ringing", 32'd0});
        sb.push_back('{"async_reset_armed", 32'h0});
        sb.push_back('{"async_reset_time", hms(0, 0, 0)});
        reset = 1'b1;
        #1;
        e = sb.pop_front(); checks++;
        obs = 32'(bus.alarm_ringing);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;
        e = sb.pop_front(); checks++;
        obs = 32'(bus.armed);
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;
        e = sb.pop_front(); checks++;
        obs = {15'd0, bus.cur_hours, bus.cur_minutes, bus.cur_seconds};
        if (obs !== e.value) $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.value); else passes++;
        @(negedge clock);
        reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_match();
        test_priority();
        test_snooze();
        test_disable();
        test_autostop();
        test_reset_mid_ring();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
